// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-mode clock divider family.
package clk_div_pkg;

    typedef enum logic [0:0] {
        SW_DEFERRED,
        SW_IMMEDIATE
    } switch_policy_e;

    localparam int unsigned DIV_8237 = 8237;
    localparam int unsigned DIV_1918 = 1918;

    localparam int unsigned MAX_TABLE_W = 256;
    typedef logic [MAX_TABLE_W-1:0] div_table_t;

    // Packs up to four terminal counts, entry 0 in the LSBs; callers truncate to N_MODES*CNT_W.
    function automatic div_table_t pack_div_table(input int unsigned cnt_w,
                                                  input int unsigned e0,
                                                  input int unsigned e1,
                                                  input int unsigned e2,
                                                  input int unsigned e3);
        div_table_t  t;
        int unsigned ent [4];
        t      = '0;
        ent[0] = e0;
        ent[1] = e1;
        ent[2] = e2;
        ent[3] = e3;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < int'(cnt_w); b++) begin
                if (b < 32 && (i * int'(cnt_w) + b) < int'(MAX_TABLE_W)) begin
                    t[i * int'(cnt_w) + b] = ent[i][b];
                end
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/div_term_lookup.sv
// Combinational mux from a mode index to its terminal count.
module div_term_lookup #(
    parameter int unsigned              CNT_W     = 14,
    parameter int unsigned              N_MODES   = 4,
    parameter logic [N_MODES*CNT_W-1:0] DIV_TABLE = '0,
    localparam int unsigned             SEL_W     = $clog2(N_MODES)
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [CNT_W-1:0] term_o
);

    always_comb begin
        term_o = '0;
        for (int i = 0; i < int'(N_MODES); i++) begin
            if (sel_i == SEL_W'(i)) begin
                term_o = DIV_TABLE[i*CNT_W +: CNT_W];
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-mode square-wave divider: half-period is table[active_mode]+1 input cycles.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned              CNT_W         = 14,
    parameter int unsigned              N_MODES       = 4,
    parameter logic [N_MODES*CNT_W-1:0] DIV_TABLE     =
        (N_MODES*CNT_W)'(pack_div_table(CNT_W, DIV_8237, DIV_1918, 0, 0)),
    parameter switch_policy_e           SWITCH_POLICY = SW_DEFERRED,
    parameter int unsigned              RESET_MODE    = 0,
    localparam int unsigned             SEL_W         = $clog2(N_MODES)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             run,
    input  logic [SEL_W-1:0] mode,
    output logic             clk_out,
    output logic             tick,
    output logic [SEL_W-1:0] active_mode,
    output logic             pending,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] term;
    logic             terminal;
    logic             mode_valid;

    div_term_lookup #(
        .CNT_W     (CNT_W),
        .N_MODES   (N_MODES),
        .DIV_TABLE (DIV_TABLE)
    ) u_lookup (
        .sel_i  (active_q),
        .term_o (term)
    );

    assign mode_valid = (32'(mode) < N_MODES);

    // ">=" lets an immediate switch catch a count already past a smaller terminal.
    assign terminal = (SWITCH_POLICY == SW_IMMEDIATE) ? (cnt_q >= term) : (cnt_q == term);

    always_comb begin
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        active_d  = active_q;
        if (run) begin
            if (terminal) begin
                cnt_d     = '0;
                clk_out_d = ~clk_out_q;
                tick_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (mode_valid && (SWITCH_POLICY == SW_IMMEDIATE || terminal)) begin
                active_d = mode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!en) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            active_q  <= SEL_W'(RESET_MODE);
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            active_q  <= active_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign active_mode = active_q;
    assign cnt         = cnt_q;
    assign pending     = mode_valid && (mode != active_q);

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: deferred, immediate and zero-terminal instances.
module tb_clk_div_multi;
    import clk_div_pkg::*;

    logic clk;
    int   edge_n;
    int   n_cmp;
    int   n_bad;

    // Shared stimulus for the deferred (d_) and immediate (i_) instances.
    logic        en_a, run_a;
    logic [1:0]  mode_a;
    logic        d_clk_out, d_tick, d_pending;
    logic [1:0]  d_active;
    logic [13:0] d_cnt;
    logic        i_clk_out, i_tick, i_pending;
    logic [1:0]  i_active;
    logic [13:0] i_cnt;

    // Three-entry table with entry 2 = 0, immediate policy.
    logic        en_z, run_z;
    logic [1:0]  mode_z;
    logic        z_clk_out, z_tick, z_pending;
    logic [1:0]  z_active;
    logic [13:0] z_cnt;

    clk_div_multi dut_def (
        .clk         (clk),
        .en          (en_a),
        .run         (run_a),
        .mode        (mode_a),
        .clk_out     (d_clk_out),
        .tick        (d_tick),
        .active_mode (d_active),
        .pending     (d_pending),
        .cnt         (d_cnt)
    );

    clk_div_multi #(
        .SWITCH_POLICY (SW_IMMEDIATE)
    ) dut_imm (
        .clk         (clk),
        .en          (en_a),
        .run         (run_a),
        .mode        (mode_a),
        .clk_out     (i_clk_out),
        .tick        (i_tick),
        .active_mode (i_active),
        .pending     (i_pending),
        .cnt         (i_cnt)
    );

    clk_div_multi #(
        .N_MODES       (3),
        .DIV_TABLE     (42'(pack_div_table(14, 8237, 1918, 0, 0))),
        .SWITCH_POLICY (SW_IMMEDIATE)
    ) dut_zero (
        .clk         (clk),
        .en          (en_z),
        .run         (run_z),
        .mode        (mode_z),
        .clk_out     (z_clk_out),
        .tick        (z_tick),
        .active_mode (z_active),
        .pending     (z_pending),
        .cnt         (z_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            edge_n++;
        end
    endtask

    // Leaves en=1, run=1 at a negedge; the next rising edge is running edge 1.
    task automatic reset_a(input logic [1:0] m);
        en_a   = 1'b0;
        run_a  = 1'b0;
        mode_a = m;
        step(2);
        en_a   = 1'b1;
        run_a  = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        en_a = 1'b0; run_a = 1'b1; mode_a = 2'd0;
        en_z = 1'b0; run_z = 1'b1; mode_z = 2'd0;
        step(2);
        n_cmp++;
        if (d_cnt !== 14'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d expected 0", d_cnt);
        end
        n_cmp++;
        if (d_clk_out !== 1'b0 || d_tick !== 1'b0) begin
            n_bad++; $display("FAIL reset_out: got clk_out=%b tick=%b expected 0 0", d_clk_out, d_tick);
        end
        n_cmp++;
        if (d_active !== 2'd0 || d_pending !== 1'b0) begin
            n_bad++; $display("FAIL reset_mode: got active=%0d pending=%b expected 0 0", d_active, d_pending);
        end
        n_cmp++;
        if (z_cnt !== 14'd0 || z_clk_out !== 1'b0 || z_active !== 2'd0) begin
            n_bad++; $display("FAIL reset_zero_inst: got cnt=%0d clk_out=%b active=%0d expected 0 0 0",
                              z_cnt, z_clk_out, z_active);
        end
    endtask

    task automatic test_first_toggle();
        int   rise, fall, nt, misalign;
        logic prev;
        reset_a(2'd0);
        rise = -1; fall = -1; nt = 0; misalign = 0; prev = 1'b0;
        for (int e = 1; e <= 16476; e++) begin
            step(1);
            if (d_clk_out === 1'b1 && prev === 1'b0 && rise < 0) rise = e;
            if (d_clk_out === 1'b0 && prev === 1'b1 && fall < 0) fall = e;
            if (d_tick === 1'b1) nt++;
            if (d_tick !== (d_clk_out ^ prev)) misalign++;
            prev = d_clk_out;
        end
        n_cmp++;
        if (rise !== 8238) begin
            n_bad++; $display("FAIL first_rise: got edge %0d expected 8238", rise);
        end
        n_cmp++;
        if (fall !== 16476) begin
            n_bad++; $display("FAIL first_fall: got edge %0d expected 16476", fall);
        end
        n_cmp++;
        if (nt !== 2) begin
            n_bad++; $display("FAIL tick_count: got %0d expected 2", nt);
        end
        n_cmp++;
        if (misalign !== 0) begin
            n_bad++; $display("FAIL tick_align: got %0d misaligned edges expected 0", misalign);
        end
        n_cmp++;
        if (d_cnt !== 14'd0) begin
            n_bad++; $display("FAIL cnt_after_fall: got %0d expected 0", d_cnt);
        end
    endtask

    task automatic test_mode_switch();
        int d_ticks[$];
        int i_ticks[$];
        int bad_pend;
        int exp_i[3];
        exp_i[0] = 5002; exp_i[1] = 6921; exp_i[2] = 8840;
        bad_pend = 0;
        reset_a(2'd0);
        step(5000);
        n_cmp++;
        if (d_cnt !== 14'd5000 || i_cnt !== 14'd5000) begin
            n_bad++; $display("FAIL sw_cnt5000: got def=%0d imm=%0d expected 5000", d_cnt, i_cnt);
        end
        mode_a = 2'd1;
        #1;
        n_cmp++;
        if (d_pending !== 1'b1) begin
            n_bad++; $display("FAIL def_pending_set: got %b expected 1", d_pending);
        end
        for (int e = 5001; e <= 10160; e++) begin
            step(1);
            if (e == 5001) begin
                n_cmp++;
                if (i_active !== 2'd1 || i_pending !== 1'b0 || i_clk_out !== 1'b0) begin
                    n_bad++; $display("FAIL imm_load: got active=%0d pending=%b clk_out=%b expected 1 0 0",
                                      i_active, i_pending, i_clk_out);
                end
            end
            if (e == 5002) begin
                n_cmp++;
                if (i_tick !== 1'b1 || i_clk_out !== 1'b1 || i_cnt !== 14'd0) begin
                    n_bad++; $display("FAIL imm_toggle: got tick=%b clk_out=%b cnt=%0d expected 1 1 0",
                                      i_tick, i_clk_out, i_cnt);
                end
            end
            if (e <= 8237 && (d_pending !== 1'b1 || d_active !== 2'd0)) bad_pend++;
            if (e == 8238) begin
                n_cmp++;
                if (d_active !== 2'd1 || d_pending !== 1'b0 || d_clk_out !== 1'b1) begin
                    n_bad++; $display("FAIL def_load: got active=%0d pending=%b clk_out=%b expected 1 0 1",
                                      d_active, d_pending, d_clk_out);
                end
            end
            if (d_tick === 1'b1) d_ticks.push_back(e);
            if (i_tick === 1'b1) i_ticks.push_back(e);
        end
        n_cmp++;
        if (bad_pend !== 0) begin
            n_bad++; $display("FAIL def_pending_hold: got %0d bad edges expected 0", bad_pend);
        end
        n_cmp++;
        if (d_ticks.size() !== 2 || d_ticks[0] !== 8238 || d_ticks[1] !== 10157) begin
            n_bad++; $display("FAIL def_ticks: got n=%0d first=%0d second=%0d expected 2 8238 10157",
                              d_ticks.size(), (d_ticks.size() > 0) ? d_ticks[0] : -1,
                              (d_ticks.size() > 1) ? d_ticks[1] : -1);
        end
        n_cmp++;
        if (i_ticks.size() !== 3 || i_ticks[0] !== exp_i[0] || i_ticks[1] !== exp_i[1]
            || i_ticks[2] !== exp_i[2]) begin
            n_bad++; $display("FAIL imm_ticks: got n=%0d first=%0d last=%0d expected 3 5002 8840",
                              i_ticks.size(), (i_ticks.size() > 0) ? i_ticks[0] : -1,
                              (i_ticks.size() > 0) ? i_ticks[i_ticks.size()-1] : -1);
        end
    endtask

    task automatic test_run_hold();
        int bad;
        bad = 0;
        reset_a(2'd0);
        step(300);
        run_a  = 1'b0;
        mode_a = 2'd1;
        for (int e = 0; e < 100; e++) begin
            step(1);
            if (d_cnt !== 14'd300 || d_clk_out !== 1'b0 || d_tick !== 1'b0
                || d_pending !== 1'b1 || d_active !== 2'd0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL run_hold: got %0d bad cycles expected 0 (cnt now %0d)", bad, d_cnt);
        end
        run_a = 1'b1;
        step(1);
        n_cmp++;
        if (d_cnt !== 14'd301 || d_active !== 2'd0) begin
            n_bad++; $display("FAIL run_resume: got cnt=%0d active=%0d expected 301 0", d_cnt, d_active);
        end
    endtask

    task automatic test_reset_on_toggle();
        reset_a(2'd1);
        step(8237);
        n_cmp++;
        if (d_cnt !== 14'd8237) begin
            n_bad++; $display("FAIL pre_reset_cnt: got %0d expected 8237", d_cnt);
        end
        en_a = 1'b0;
        step(1);
        n_cmp++;
        if (d_cnt !== 14'd0 || d_clk_out !== 1'b0 || d_tick !== 1'b0 || d_active !== 2'd0) begin
            n_bad++; $display("FAIL reset_override: got cnt=%0d clk_out=%b tick=%b active=%0d expected 0 0 0 0",
                              d_cnt, d_clk_out, d_tick, d_active);
        end
    endtask

    task automatic test_zero_term();
        int bad;
        bad    = 0;
        en_z   = 1'b0;
        run_z  = 1'b0;
        mode_z = 2'd2;
        step(2);
        en_z   = 1'b1;
        run_z  = 1'b1;
        step(1);
        n_cmp++;
        if (z_active !== 2'd2 || z_pending !== 1'b0 || z_cnt !== 14'd1) begin
            n_bad++; $display("FAIL zero_load: got active=%0d pending=%b cnt=%0d expected 2 0 1",
                              z_active, z_pending, z_cnt);
        end
        for (int e = 2; e <= 21; e++) begin
            step(1);
            if (z_tick !== 1'b1 || z_clk_out !== logic'((e - 1) % 2) || z_cnt !== 14'd0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL zero_toggle: got %0d bad cycles expected 0", bad);
        end
        mode_z = 2'd3;
        #1;
        n_cmp++;
        if (z_pending !== 1'b0) begin
            n_bad++; $display("FAIL oor_pending: got %b expected 0", z_pending);
        end
        step(5);
        n_cmp++;
        if (z_active !== 2'd2 || z_tick !== 1'b1) begin
            n_bad++; $display("FAIL oor_ignored: got active=%0d tick=%b expected 2 1", z_active, z_tick);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        edge_n = 0;
        en_a = 1'b0; run_a = 1'b0; mode_a = 2'd0;
        en_z = 1'b0; run_z = 1'b0; mode_z = 2'd0;
        test_reset();
        test_first_toggle();
        test_mode_switch();
        test_run_hold();
        test_reset_on_toggle();
        test_zero_term();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-mode clock divider. It generates a square wave `clk_out` whose half-period is chosen at run time from a table of `N_MODES` terminal counts. Mode changes take effect either at the next half-period boundary or immediately, depending on policy, so the output never glitches shorter than one input cycle. It sits between the system clock and tone, LED and scan-timing consumers, replacing fixed two-mode dividers.

## Interface
- `CNT_W`, 14: counter width; terminal counts are `CNT_W` bits.
- `N_MODES`, 4: number of table entries, ≥ 2.
- `SEL_W`, `$clog2(N_MODES)`: width of the mode select; derived, not overridden.
- `DIV_TABLE`, {1918, 8237} in entries 1 and 0, remaining entries 0 unless overridden: packed `N_MODES*CNT_W` terminal counts, with entry 0 in the LSBs.
- `SWITCH_POLICY`, `SW_DEFERRED`: `SW_DEFERRED` or `SW_IMMEDIATE`.
- `RESET_MODE`, 0: active mode after reset.

Ports:
- `clk`, in, 1: the single clock; all logic on its rising edge.
- `en`, in, 1: synchronous, active-low reset.
- `run`, in, 1: count enable. When low, all state holds.
- `mode`, in, `SEL_W`: requested mode, sampled every cycle.
- `clk_out`, out, 1: divided square wave, registered.
- `tick`, out, 1: one-cycle pulse, coincident with each `clk_out` transition.
- `active_mode`, out, `SEL_W`: mode currently governing the count.
- `pending`, out, 1: a mode request is waiting. Combinational: (`mode` != `active_mode`) and `mode` < `N_MODES`.
- `cnt`, out, `CNT_W`: current count, for debug and verification.

## Operation
- `T` = `DIV_TABLE[active_mode]`. The counter runs 0..`T`, so each half-period is `T`+1 cycles and the full period is 2(`T`+1).
- Reset (`en`=0 at an edge): `cnt`=0, `clk_out`=0, `tick`=0, `active_mode`=`RESET_MODE`, regardless of `run`.
- `run`=1 and the terminal condition holds: the next edge sets `cnt`←0, `clk_out`←~`clk_out`, `tick`←1. Otherwise `cnt`←`cnt`+1 and `tick`←0.
- Terminal condition by policy:
  - `SW_DEFERRED`: `cnt`==`T`.
  - `SW_IMMEDIATE`: `cnt`≥`T`. This catches a count already past a newly smaller `T`.
- `SW_DEFERRED`:
  - `active_mode` loads `mode` only on the edge that performs a toggle.
  - The new `T` governs the half-period starting at `cnt`=0.
- `SW_IMMEDIATE`:
  - `active_mode` loads `mode` on every edge with `run`=1.
  - The compare uses the registered `active_mode`, so a request takes effect on the cycle after sampling.
- Out-of-range `mode` (≥ `N_MODES`) is ignored: `active_mode` is kept and `pending`=0.
- `run`=0: `cnt`, `clk_out` and `active_mode` hold, and `tick`=0. A deferred request stays pending until a toggle occurs with `run`=1.
- `T`=0: `clk_out` toggles every running cycle (clk/2) and `tick` stays high.
- `cnt` never wraps. `T`≤2^`CNT_W`−1 by construction.

## Timing
- All outputs are registered except `pending`.
- First toggle after reset release with `run`=1: `clk_out` rises `T`+1 edges after the first running edge.
- `tick` and the `clk_out` edge occur in the same cycle, with no additional latency.
- Immediate mode: a request causes a toggle at most 2 edges later when the old `cnt` ≥ new `T`.
- `en`=0 mid-count overrides everything at the next edge, including a coincident toggle or mode load.

## Structure
- Package `clk_div_pkg` holds:
  - `switch_policy_e` enum (`SW_DEFERRED`, `SW_IMMEDIATE`);
  - default terminal constants `DIV_8237` and `DIV_1918`;
  - a helper function to build a packed `DIV_TABLE`.
- One sub-module: `div_term_lookup`, a combinational table mux from `active_mode` to `T`. It is reused by future multi-channel variants.
- The counter, toggle and policy logic stay in the top module.

## Test plan
- Defaults, mode 0, `run`=1 after reset: first `clk_out` rise at edge 8238, fall at 16476. `tick` fires exactly on those edges.
- Deferred policy, `mode` 0→1 at `cnt`=5000: `pending`=1 until the toggle at `cnt`=8237. `active_mode` becomes 1 on that edge, and the next half-period is 1919 cycles.
- Immediate policy, same stimulus: `active_mode`=1 one edge later, toggle on the following edge. Subsequent half-periods are 1919 cycles.
- `run`=0 for 100 cycles at `cnt`=300 with a mode request: `cnt` stays 300, `clk_out` is unchanged, `tick`=0, the request stays pending. Counting resumes from 301.
- `en`=0 at `cnt`=8237 (coincident toggle): the next edge gives `cnt`=0, `clk_out`=0, `tick`=0, `active_mode`=`RESET_MODE`.
- Table entry 2 = 0, `mode`=2, plus `mode`=3 out of range with `N_MODES`=3:
  - entry 2: `clk_out` toggles every cycle and `tick` is held high;
  - `mode`=3: ignored, `pending`=0.
